keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
Sequencer between the 4x4 keypad scanner's one-hot key vector and the 3-digit BCD display path. Debounces press and release, decodes each accepted press exactly once, and manages a 3-digit entry buffer with digit, clear, backspace and enter keys. Publishes the live buffer for display and a committed value with a one-cycle valid strobe.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical samples needed to accept a press or a release (2..65535; production uses the 20 ms equivalent)
CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock
rst_n  input  1  reset
onehot  input  16  scanner key vector; one bit high while a key is held, 0 when none
digits  output  12  live entry buffer, BCD; [3:0] newest digit, [11:8] oldest
digit_count  output  2  digits in buffer, 0..3
entry_value  output  12  last committed BCD value
entry_valid  output  1  one-cycle pulse when entry_value updates
key_err  output  1  one-cycle pulse on a rejected key action

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Reset: all outputs 0, FSM in IDLE, counter 0, latched code 0.
- Key map:
  - Digit keys: 0x0008=0, 0x0080=1, 0x0040=2, 0x0020=3, 0x0800=4, 0x0400=5, 0x0200=6, 0x8000=7, 0x4000=8, 0x2000=9.
  - Control keys: 0x0001=CLEAR, 0x0002=BACKSPACE, 0x0004=ENTER.
  - 0x0010, 0x0100, 0x1000 are unused: they are debounced and then ignored, with no error.
  - Any vector with more than one bit set is treated as 0, i.e. no key.
- FSM states:
  - IDLE: on a valid nonzero vector, latch it, cnt=1, go to PRESS_DB.
  - PRESS_DB:
    - Sample equals latched code: cnt++.
    - Sample is a different valid code: relatch, cnt=1.
    - Sample is 0: go to IDLE.
    - When cnt reaches DEBOUNCE_CYCLES, execute the action on that same edge and go to HELD.
  - HELD: all nonzero vectors are ignored. On 0, cnt=1 and go to REL_DB.
  - REL_DB:
    - 0 sampled: cnt++.
    - Nonzero sampled: go back to HELD.
    - When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
- Latency: a key first sampled at edge 0 acts at edge DEBOUNCE_CYCLES-1. Held keys never repeat.
- Actions:
  - DIGIT d:
    - count<3: digits <= {digits[7:0], d}, count++.
    - count==3: buffer unchanged, key_err pulse.
  - BACKSPACE:
    - count>0: digits <= {4'h0, digits[11:4]}, count--.
    - count==0: key_err pulse.
  - CLEAR: digits=0, count=0. Never an error.
  - ENTER:
    - count>0: entry_value <= digits, entry_valid pulse, digits=0, count=0, all on one edge.
    - count==0: key_err pulse, entry_value held.
- entry_valid and key_err are mutually exclusive and last exactly one cycle.
- rst_n low in any state (including mid-debounce or HELD) returns everything to reset values on that edge. A key still held when reset is released is debounced as a fresh press.

Decomposition:
- Package keypad_pkg holds:
  - the key-code constants (KEY_0..KEY_9, KEY_CLR, KEY_BS, KEY_ENT);
  - the state enum (IDLE, PRESS_DB, HELD, REL_DB);
  - a decode function mapping a one-hot vector to {is_digit, is_ctrl, value[3:0]}.
- One sub-module: keypad_debouncer, containing the FSM and counter. It emits a one-cycle key_accept plus the latched code.
- The buffer and action logic live in keypad_entry_ctrl.

Test Plan:
- Press 0x0080 for 10 cycles, release, then 0x0040, then 0x0020 -> digits=0x123, count=3; each update occurs exactly 3 edges after first sample; no repeat while held.
- Press 0x0080 for 2 cycles, release for 1, press for 2, release -> no action (bounce rejected); digits=0, count=0.
- digits=0x123, press 0x0008 -> key_err pulse, digits stays 0x123. Then BACKSPACE -> digits=0x012, count=2.
- digits=0x012, ENTER -> entry_value=0x012, entry_valid high for 1 cycle, digits=0, count=0. A second ENTER -> key_err, entry_value stays 0x012.
- onehot=0x00C0 (two bits) for 20 cycles -> no action, FSM stays IDLE. Press 0x0010 -> no change, no key_err.
- Digit 5 entered, rst_n low for 1 cycle mid-press of 7 -> all outputs 0. With 7 still held after reset release -> digits=0x007 after 4 samples.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_pkg                                                    |
// | Purpose  : Shared key-code constants, debouncer state encoding and the   |
// |            one-hot key decoder used by the keypad entry controller.      |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package keypad_pkg;

  // Scanner one-hot codes for each physical key.
  localparam logic [15:0] KEY_0   = 16'h0008;
  localparam logic [15:0] KEY_1   = 16'h0080;
  localparam logic [15:0] KEY_2   = 16'h0040;
  localparam logic [15:0] KEY_3   = 16'h0020;
  localparam logic [15:0] KEY_4   = 16'h0800;
  localparam logic [15:0] KEY_5   = 16'h0400;
  localparam logic [15:0] KEY_6   = 16'h0200;
  localparam logic [15:0] KEY_7   = 16'h8000;
  localparam logic [15:0] KEY_8   = 16'h4000;
  localparam logic [15:0] KEY_9   = 16'h2000;
  localparam logic [15:0] KEY_CLR = 16'h0001;
  localparam logic [15:0] KEY_BS  = 16'h0002;
  localparam logic [15:0] KEY_ENT = 16'h0004;

  // Control-key identifiers carried in the value field of a decoded key.
  localparam logic [3:0] CTRL_CLR = 4'd0;
  localparam logic [3:0] CTRL_BS  = 4'd1;
  localparam logic [3:0] CTRL_ENT = 4'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } db_state_e;

  typedef struct packed {
    logic       is_digit;
    logic       is_ctrl;
    logic [3:0] value;
  } key_decode_t;

  // Unused keys and anything not in the map decode to all-zero (ignored).
  function automatic key_decode_t decode_key(input logic [15:0] code);
    key_decode_t d;
    d = '0;
    case (code)
      KEY_0:   begin d.is_digit = 1'b1; d.value = 4'd0; end
      KEY_1:   begin d.is_digit = 1'b1; d.value = 4'd1; end
      KEY_2:   begin d.is_digit = 1'b1; d.value = 4'd2; end
      KEY_3:   begin d.is_digit = 1'b1; d.value = 4'd3; end
      KEY_4:   begin d.is_digit = 1'b1; d.value = 4'd4; end
      KEY_5:   begin d.is_digit = 1'b1; d.value = 4'd5; end
      KEY_6:   begin d.is_digit = 1'b1; d.value = 4'd6; end
      KEY_7:   begin d.is_digit = 1'b1; d.value = 4'd7; end
      KEY_8:   begin d.is_digit = 1'b1; d.value = 4'd8; end
      KEY_9:   begin d.is_digit = 1'b1; d.value = 4'd9; end
      KEY_CLR: begin d.is_ctrl  = 1'b1; d.value = CTRL_CLR; end
      KEY_BS:  begin d.is_ctrl  = 1'b1; d.value = CTRL_BS;  end
      KEY_ENT: begin d.is_ctrl  = 1'b1; d.value = CTRL_ENT; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_entry_ctrl_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_debouncer                                              |
// | Purpose  : Press/release debouncer for the scanner one-hot vector.       |
// |            Emits a single-cycle accept on the edge a press becomes       |
// |            stable; held keys never re-trigger until a stable release.    |
// | Ports    : clk, rst_n (sync, active-low)                                 |
// |            onehot_i     [15:0] raw scanner vector                        |
// |            key_accept_o        accepted-press strobe (combinational)     |
// |            key_code_o   [15:0] latched code, valid with key_accept_o     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] onehot_i,
  output logic        key_accept_o,
  output logic [15:0] key_code_o
);

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      code_q, code_d;
  logic             sample_valid;
  logic [CNT_W-1:0] cnt_inc;

  // Exactly one bit set; multi-bit vectors are treated as "no key".
  assign sample_valid = (onehot_i != 16'h0) && ((onehot_i & (onehot_i - 16'd1)) == 16'h0);
  assign cnt_inc      = cnt_q + CNT_ONE;
  assign key_code_o   = code_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    key_accept_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          code_d  = onehot_i;
          cnt_d   = CNT_ONE;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!sample_valid) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (onehot_i != code_q) begin
          code_d = onehot_i;
          cnt_d  = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
          // Action fires on the same edge the count completes.
          if (cnt_inc == CNT_DONE) begin
            key_accept_o = 1'b1;
            state_d      = HELD;
          end
        end
      end
      HELD: begin
        if (!sample_valid) begin
          cnt_d   = CNT_ONE;
          state_d = REL_DB;
        end
      end
      REL_DB: begin
        if (sample_valid) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_DONE) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule : keypad_debouncer
`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_entry_ctrl                                             |
// | Purpose  : 3-digit BCD entry buffer driven by debounced keypad presses.  |
// |            Handles digit, clear, backspace and enter actions.            |
// | Ports    : clk, rst_n (sync, active-low)                                 |
// |            onehot      [15:0] scanner key vector                         |
// |            digits      [11:0] live buffer, [3:0] newest digit            |
// |            digit_count [1:0]  digits currently in buffer                 |
// |            entry_value [11:0] last committed value                       |
// |            entry_valid        one-cycle commit strobe                    |
// |            key_err            one-cycle rejected-action strobe           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] onehot,
  output logic [11:0] digits,
  output logic [1:0]  digit_count,
  output logic [11:0] entry_value,
  output logic        entry_valid,
  output logic        key_err
);

  logic        key_accept;
  logic [15:0] key_code;
  key_decode_t key;

  logic [11:0] digits_q, digits_d;
  logic [1:0]  count_q, count_d;
  logic [11:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  keypad_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clk          (clk),
    .rst_n        (rst_n),
    .onehot_i     (onehot),
    .key_accept_o (key_accept),
    .key_code_o   (key_code)
  );

  assign key = decode_key(key_code);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_q <= '0;
      count_q  <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (key_accept) begin
      if (key.is_digit) begin
        if (count_q != 2'd3) begin
          digits_d = {digits_q[7:0], key.value};
          count_d  = count_q + 2'd1;
        end else begin
          err_d = 1'b1;
        end
      end else if (key.is_ctrl) begin
        case (key.value)
          CTRL_CLR: begin
            digits_d = '0;
            count_d  = '0;
          end
          CTRL_BS: begin
            if (count_q != 2'd0) begin
              digits_d = {4'h0, digits_q[11:4]};
              count_d  = count_q - 2'd1;
            end else begin
              err_d = 1'b1;
            end
          end
          CTRL_ENT: begin
            if (count_q != 2'd0) begin
              value_d  = digits_q;
              valid_d  = 1'b1;
              digits_d = '0;
              count_d  = '0;
            end else begin
              err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign digits      = digits_q;
  assign digit_count = count_q;
  assign entry_value = value_q;
  assign entry_valid = valid_q;
  assign key_err     = err_q;

endmodule : keypad_entry_ctrl
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_keypad_entry_ctrl                                          |
// | Purpose  : Self-checking bench: directed scenarios then random key       |
// |            streams, compared every cycle against a run-length / queue    |
// |            reference model.                                              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_keypad_entry_ctrl;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] onehot = 16'h0;
  logic [11:0] digits;
  logic [1:0]  digit_count;
  logic [11:0] entry_value;
  logic        entry_valid;
  logic        key_err;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .onehot      (onehot),
    .digits      (digits),
    .digit_count (digit_count),
    .entry_value (entry_value),
    .entry_valid (entry_valid),
    .key_err     (key_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: a press is taken once the same single key has been seen
  // for DEB consecutive samples while armed; it re-arms once "no key" has been
  // seen for DEB consecutive samples. Buffer is a queue, oldest digit first.
  bit          armed = 1'b1;
  int          run   = 0;
  logic [15:0] lcode = 16'h0;
  int          q[$];
  logic [11:0] m_val   = 12'h0;
  bit          m_valid = 1'b0;
  bit          m_err   = 1'b0;

  function automatic int digit_of(input logic [15:0] v);
    case (v)
      16'h0008: return 0;  16'h0080: return 1;  16'h0040: return 2;
      16'h0020: return 3;  16'h0800: return 4;  16'h0400: return 5;
      16'h0200: return 6;  16'h8000: return 7;  16'h4000: return 8;
      16'h2000: return 9;
      default:  return -1;
    endcase
  endfunction

  function automatic logic [11:0] packed_buf();
    logic [11:0] r;
    r = 12'h0;
    foreach (q[i]) r = {r[7:0], 4'(q[i])};
    return r;
  endfunction

  task automatic do_action(input logic [15:0] v);
    int d;
    d = digit_of(v);
    if (d >= 0) begin
      if (q.size() < 3) q.push_back(d); else m_err = 1'b1;
    end else if (v == 16'h0001) begin
      q.delete();
    end else if (v == 16'h0002) begin
      if (q.size() > 0) void'(q.pop_back()); else m_err = 1'b1;
    end else if (v == 16'h0004) begin
      if (q.size() > 0) begin
        m_val   = packed_buf();
        m_valid = 1'b1;
        q.delete();
      end else m_err = 1'b1;
    end
  endtask

  task automatic model_step(input logic [15:0] v, input logic r);
    bit single;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!r) begin
      armed = 1'b1; run = 0; lcode = 16'h0; q.delete(); m_val = 12'h0;
      return;
    end
    single = ($countones(v) == 1);
    if (armed) begin
      if (single) begin
        if (run > 0 && v == lcode) run++;
        else begin lcode = v; run = 1; end
        if (run == DEB) begin do_action(lcode); armed = 1'b0; run = 0; end
      end else run = 0;
    end else begin
      if (!single) run++; else run = 0;
      if (run == DEB) begin armed = 1'b1; run = 0; end
    end
  endtask

  task automatic check_all();
    chk("digits",      32'(digits),      32'(packed_buf()));
    chk("digit_count", 32'(digit_count), 32'(q.size()));
    chk("entry_value", 32'(entry_value), 32'(m_val));
    chk("entry_valid", 32'(entry_valid), 32'(m_valid));
    chk("key_err",     32'(key_err),     32'(m_err));
  endtask

  task automatic cycle(input logic [15:0] v, input logic r);
    onehot = v;
    rst_n  = r;
    @(posedge clk);
    model_step(v, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(v, 1'b1);
  endtask

  initial begin
    logic [15:0] one;
    logic [15:0] v;
    int k, a, b;
    one = 16'h0001;

    // Reset state
    cycle(16'h0, 1'b0);
    cycle(16'h0, 1'b0);

    // Three digits, long holds: no repeat while held
    hold(16'h0080, 10); hold(16'h0, 6);
    hold(16'h0040, 10); hold(16'h0, 6);
    hold(16'h0020, 10); hold(16'h0, 6);
    chk("tp_digits_123", 32'(digits), 32'h123);
    chk("tp_count_3",    32'(digit_count), 32'd3);

    // Fourth digit rejected, then backspace
    hold(16'h0008, 6); hold(16'h0, 6);
    chk("tp_full_digits", 32'(digits), 32'h123);
    hold(16'h0002, 6); hold(16'h0, 6);
    chk("tp_bs_digits", 32'(digits), 32'h012);
    chk("tp_bs_count",  32'(digit_count), 32'd2);

    // Enter commits, second enter rejected
    hold(16'h0004, 6); hold(16'h0, 6);
    chk("tp_ent_value", 32'(entry_value), 32'h012);
    chk("tp_ent_count", 32'(digit_count), 32'd0);
    hold(16'h0004, 6); hold(16'h0, 6);
    chk("tp_ent2_value", 32'(entry_value), 32'h012);

    // Bounce rejected
    hold(16'h0080, 2); hold(16'h0, 1); hold(16'h0080, 2); hold(16'h0, 6);
    chk("tp_bounce", 32'(digits), 32'h0);

    // Multi-bit vector and unused key
    hold(16'h00C0, 20); hold(16'h0, 2);
    hold(16'h0010, 6); hold(16'h0, 6);
    chk("tp_unused", 32'(digits), 32'h0);

    // Reset mid-press, key still held afterwards is a fresh press
    hold(16'h0400, 6); hold(16'h0, 6);
    hold(16'h8000, 2);
    cycle(16'h8000, 1'b0);
    chk("tp_rst_digits", 32'(digits), 32'h0);
    hold(16'h8000, 4);
    chk("tp_after_rst", 32'(digits), 32'h007);
    hold(16'h0, 6);

    // Random key streams
    for (int s = 0; s < 400; s++) begin
      k = $urandom_range(0, 39);
      if (k < 30) begin
        v = one << $urandom_range(0, 15);
      end else if (k < 34) begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        v = (one << a) | (one << b);
      end else if (k < 38) begin
        v = 16'h0;
      end else begin
        cycle(one << $urandom_range(0, 15), 1'b0);
        v = 16'h0;
      end
      hold(v, $urandom_range(1, 7));
      hold(16'h0, $urandom_range(0, 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_keypad_entry_ctrl
`default_nettype wire
